// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH iterations of one partial product per cycle,
// signed or unsigned per operation, full 2*WIDTH-bit product with zero/negative/overflow flags.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           ZN,
  output logic                 ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_ma;
  logic [PW-1:0]     r_acc;
  logic [WIDTH-1:0]  r_mb;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              r_mode;
  logic [PW-1:0]     w_prod;

  // Magnitude in WIDTH unsigned bits; the most-negative value maps onto itself exactly.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic ovf_f(input logic [PW-1:0] p, input logic s);
    logic [WIDTH:0] w_top;
    w_top = p[PW-1:WIDTH-1];
    if (s)
      return !((&w_top) || !(|w_top));
    else
      return |p[PW-1:WIDTH];
  endfunction

  assign w_prod = r_neg ? (~r_acc + PW'(1)) : r_acc;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_SIGN;
      S_SIGN:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_mode  <= 1'b0;
      product <= '0;
      ZN      <= 2'b10;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= signed_mode;
            r_ma   <= {{WIDTH{1'b0}}, mag(a, signed_mode)};
            r_mb   <= mag(b, signed_mode);
            r_neg  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          if (r_mb[0]) r_acc <= r_acc + r_ma;
          r_ma  <= r_ma << 1;
          r_mb  <= r_mb >> 1;
          r_cnt <= r_cnt + CW'(1);
        end
        // Result and flags are committed together on the SIGN->DONE edge only.
        S_SIGN: begin
          product <= w_prod;
          ZN      <= {(w_prod == '0), r_mode & w_prod[PW-1]};
          ovf     <= ovf_f(w_prod, r_mode);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed WIDTH=16 vectors plus swept WIDTH=4/8/16 instances.
module tb_seq_multiplier;

  typedef struct {
    logic [63:0] p;
    logic [1:0]  zn;
    logic        ovf;
    int          t0;
  } exp_t;

  localparam int NSWEEP = 1000;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int sweeps_done = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input bit s);
    exp_t r;
    longint ex, ey, pr;
    ex = longint'(x);
    ey = longint'(y);
    if (s && x[w-1]) ex = ex - (longint'(1) << w);
    if (s && y[w-1]) ey = ey - (longint'(1) << w);
    pr = ex * ey;
    r.p  = 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    r.zn = {r.p == 64'd0, s & r.p[2*w-1]};
    if (s) r.ovf = (pr < -(longint'(1) << (w - 1))) || (pr >= (longint'(1) << (w - 1)));
    else   r.ovf = (pr >= (longint'(1) << w));
    r.t0 = 0;
    return r;
  endfunction

  // Directed WIDTH=16 instance
  logic        rst, st, sm;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] p16;
  logic [1:0]  zn16;
  logic        ovf16;
  exp_t        q16[$];

  seq_multiplier #(.WIDTH(16)) u_dut (
    .clock(clk), .reset(rst), .start(st), .signed_mode(sm), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(p16), .ZN(zn16), .ovf(ovf16)
  );

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL d16_unexpected_done: got done=1 expected no pulse (product %0h)", p16);
      end else begin
        e = q16.pop_front();
        check("d16_product", 64'(p16), e.p);
        check("d16_zn", 64'(zn16), 64'(e.zn));
        check("d16_ovf", 64'(ovf16), 64'(e.ovf));
        check("d16_latency", 64'(cyc - e.t0), 64'(17));
      end
    end
  end

  task automatic wait_idle16();
    int n = 0;
    while (busy16 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy16 !== 1'b0) begin
      ncmp++;
      nfail++;
      $display("FAIL d16_idle_timeout: got busy=%b expected 0", busy16);
    end
  endtask

  task automatic go16(input logic s, input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] ep, input logic [1:0] ez, input logic eo);
    exp_t e;
    wait_idle16();
    sm = s; a16 = x; b16 = y; st = 1'b1;
    @(posedge clk);
    #1;
    e.p = 64'(ep); e.zn = ez; e.ovf = eo; e.t0 = cyc;
    q16.push_back(e);
    @(negedge clk);
    st = 1'b0; a16 = ~x; b16 = ~y; sm = ~s;
  endtask

  initial begin : main
    exp_t e;
    int n;
    rst = 1'b1; st = 1'b0; sm = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_done", 64'(done16), 64'd0);
    check("rst_product", 64'(p16), 64'd0);
    check("rst_zn", 64'(zn16), 64'b10);
    check("rst_ovf", 64'(ovf16), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    go16(1'b0, 16'd9, 16'd9, 32'd81, 2'b00, 1'b0);
    n = 0;
    while (busy16 === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd18);
    repeat (3) @(negedge clk);
    check("product_hold", 64'(p16), 64'd81);

    go16(1'b1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB, 2'b01, 1'b0);
    go16(1'b1, 16'd7, 16'hFFFD, 32'hFFFF_FFEB, 2'b01, 1'b0);
    go16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 2'b00, 1'b1);
    go16(1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 2'b00, 1'b1);
    go16(1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000, 2'b01, 1'b0);
    go16(1'b1, 16'h0000, 16'h1234, 32'h0000_0000, 2'b10, 1'b0);

    // start held high through the whole operation, operands churning
    wait_idle16();
    sm = 1'b0; a16 = 16'd5; b16 = 16'd6; st = 1'b1;
    @(posedge clk);
    #1;
    e.p = 64'd30; e.zn = 2'b00; e.ovf = 1'b0; e.t0 = cyc;
    q16.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      a16 = 16'($urandom); b16 = 16'($urandom); sm = 1'($urandom);
      n++;
    end while (done16 !== 1'b1 && n < 40);
    if (done16 !== 1'b1) begin
      ncmp++;
      nfail++;
      $display("FAIL held_start_done_timeout: got done=%b expected 1", done16);
    end
    @(negedge clk);
    st = 1'b0;
    check("start_in_done_ignored", 64'(busy16), 64'd0);
    go16(1'b1, 16'd2, 16'hFFFF, 32'hFFFF_FFFE, 2'b01, 1'b0);

    // reset during RUN
    wait_idle16();
    sm = 1'b0; a16 = 16'd100; b16 = 16'd3; st = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_done", 64'(done16), 64'd0);
    check("abort_product", 64'(p16), 64'd0);
    check("abort_zn", 64'(zn16), 64'b10);
    check("abort_ovf", 64'(ovf16), 64'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    go16(1'b0, 16'd12, 16'd12, 32'd144, 2'b00, 1'b0);

    n = 0;
    while (q16.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL d16_drain: got %0d pending expected 0", q16.size());
    end

    n = 0;
    while (sweeps_done < 3 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (sweeps_done < 3) begin
      ncmp++;
      nfail++;
      $display("FAIL sweep_timeout: got %0d sweeps expected 3", sweeps_done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  // Swept instances, each with its own driver and scoreboard
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;

    logic             grst, gst, gsm;
    logic [W-1:0]     ga, gb;
    logic             gbusy, gdone;
    logic [2*W-1:0]   gp;
    logic [1:0]       gzn;
    logic             govf;
    exp_t             q[$];

    seq_multiplier #(.WIDTH(W)) u_dut (
      .clock(clk), .reset(grst), .start(gst), .signed_mode(gsm), .a(ga), .b(gb),
      .busy(gbusy), .done(gdone), .product(gp), .ZN(gzn), .ovf(govf)
    );

    always @(negedge clk) begin : mon
      exp_t e;
      if (gdone === 1'b1) begin
        if (q.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL w%0d_unexpected_done: got done=1 expected no pulse", W);
        end else begin
          e = q.pop_front();
          check($sformatf("w%0d_product", W), 64'(gp), e.p);
          check($sformatf("w%0d_zn", W), 64'(gzn), 64'(e.zn));
          check($sformatf("w%0d_ovf", W), 64'(govf), 64'(e.ovf));
          check($sformatf("w%0d_latency", W), 64'(cyc - e.t0), 64'(W + 1));
        end
      end
    end

    initial begin : drv
      exp_t r;
      int n;
      grst = 1'b1; gst = 1'b0; gsm = 1'b0; ga = '0; gb = '0;
      repeat (2) @(negedge clk);
      grst = 1'b0;
      @(negedge clk);
      for (int k = 0; k <= NSWEEP; k++) begin
        n = 0;
        while (gbusy !== 1'b0 && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (gbusy !== 1'b0) begin
          ncmp++;
          nfail++;
          $display("FAIL w%0d_idle_timeout: got busy=%b expected 0", W, gbusy);
        end
        if (k == 0) begin
          // most-negative times minus one: +2^(W-1), does not fit signed WIDTH
          gsm = 1'b1; ga = {1'b1, {(W-1){1'b0}}}; gb = '1;
          r.p = 64'd1 << (W - 1); r.zn = 2'b00; r.ovf = 1'b1;
        end else begin
          ga = W'($urandom); gb = W'($urandom); gsm = 1'($urandom);
          case ($urandom_range(0, 5))
            0: ga = '1;
            1: ga = {1'b1, {(W-1){1'b0}}};
            2: gb = '0;
            3: gb = {1'b1, {(W-1){1'b0}}};
            default: ;
          endcase
          r = ref_mul(W, 32'(ga), 32'(gb), gsm);
        end
        gst = 1'b1;
        @(posedge clk);
        #1;
        r.t0 = cyc;
        q.push_back(r);
        @(negedge clk);
        gst = 1'b0; ga = ~ga; gb = ~gb;
      end
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        ncmp++;
        nfail++;
        $display("FAIL w%0d_drain: got %0d pending expected 0", W, q.size());
      end
      sweeps_done++;
    end
  end

endmodule
